fp32_seq_divider: RTL and testbench

- Multi-cycle IEEE-754 single-precision divider (result = A / B) for the DNN floating-point datapath; it is the inverse-direction companion of the combinational Fmultiplier.
- Uses radix-2 restoring division on the 24-bit significands, with round-to-nearest-even.
- Uses a valid/ready handshake on both sides, so normalisation and softmax stages can stall it.
- Denormal inputs and outputs are flushed to zero.

---
 rtl/fp_pkg.sv | 54 +++++
 rtl/fp_round_pack.sv | 65 ++++++
 rtl/fp32_seq_divider.sv | 196 +++++++++++++++++++
 tb/tb_fp32_seq_divider.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared single-precision floating-point definitions for the DNN
//            datapath: divider state encoding, IEEE-754 constants, field
//            extraction and operand classification helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DIV   = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    FP_ZERO   = 2'd0,
    FP_NORMAL = 2'd1,
    FP_INF    = 2'd2,
    FP_NAN    = 2'd3
  } fp_class_e;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] frac;
  } fp32_t;

  function automatic fp32_t fp_fields(input logic [31:0] x);
    return fp32_t'(x);
  endfunction

  // Exponent zero is treated as zero regardless of fraction: denormals flush.
  function automatic fp_class_e fp_classify(input fp32_t f);
    if (f.exp == '0) return FP_ZERO;
    if (f.exp == '1) return (f.frac == '0) ? FP_INF : FP_NAN;
    return FP_NORMAL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_round_pack.sv
`default_nettype none
// ============================================================================
// Module   : fp_round_pack
// Purpose  : Combinational round-to-nearest-even of the raw quotient, exponent
//            overflow/underflow detection and IEEE-754 packing.
// Ports    : sign_i    - result sign
//            exp_i     - signed biased exponent (2 guard bits)
//            quo_i     - quotient: 24 significant bits, guard, round
//            sticky_i  - remainder non-zero
//            result_o  - packed single-precision result
//            exc_o     - overflow or underflow (flush) occurred
// Revision : 1.0 - initial release
// ============================================================================
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     sign_i,
  input  logic signed [EXP_W+1:0]  exp_i,
  input  logic [MAN_W+2:0]         quo_i,
  input  logic                     sticky_i,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic                     exc_o
);

  localparam int SIG_W = MAN_W + 1;
  localparam int E_W   = EXP_W + 2;
  localparam logic signed [E_W-1:0] E_MAX = E_W'(EXP_MAX);
  localparam logic signed [E_W-1:0] E_ONE = E_W'(1);

  logic [SIG_W-1:0]      mant;
  logic                  guard;
  logic                  rnd;
  logic                  inc;
  logic [SIG_W:0]        sum;
  logic [MAN_W-1:0]      frac;
  logic signed [E_W-1:0] exp_fin;

  always_comb begin
    mant  = quo_i[MAN_W+2:2];
    guard = quo_i[1];
    rnd   = quo_i[0];
    // Tie (guard set, nothing below) rounds toward an even LSB.
    inc   = guard & (rnd | sticky_i | mant[0]);
    sum   = {1'b0, mant} + {{SIG_W{1'b0}}, inc};
    // A carry out means the significand became 10.000..0; renormalise.
    frac    = sum[SIG_W] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    exp_fin = exp_i + $signed({{(E_W-1){1'b0}}, sum[SIG_W]});

    if (exp_fin >= E_MAX) begin
      result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      exc_o    = 1'b1;
    end else if (exp_fin < E_ONE) begin
      result_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
      exc_o    = 1'b1;
    end else begin
      result_o = {sign_i, exp_fin[EXP_W-1:0], frac};
      exc_o    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp32_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : fp32_seq_divider
// Purpose  : Multi-cycle IEEE-754 single-precision divider (A / B) using
//            radix-2 restoring division of the significands and RNE rounding.
//            Denormals are flushed to zero on input and output.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            in_valid/in_ready     - operand handshake (A, B)
//            out_valid/out_ready   - result handshake (result, exception)
//            exception             - NaN/invalid, div-by-zero, ovf or unf
// Revision : 1.0 - initial release
// ============================================================================
module fp32_seq_divider #(
  parameter int          EXP_W = 8,
  parameter int          MAN_W = 23,
  parameter logic [31:0] QNAN  = fp_pkg::QNAN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        exception
);

  import fp_pkg::*;

  localparam int SIG_W = MAN_W + 1;
  localparam int REM_W = SIG_W + 1;
  localparam int Q_W   = MAN_W + 3;
  localparam int E_W   = EXP_W + 2;
  localparam int CNT_W = $clog2(Q_W);

  state_e                state_q, state_d;
  logic [31:0]           a_q, a_d, b_q, b_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [SIG_W-1:0]      mb_q, mb_d;
  logic [Q_W-1:0]        quo_q, quo_d;
  logic signed [E_W-1:0] exp_q, exp_d;
  logic                  sign_q, sign_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [31:0]           result_q, result_d;
  logic                  exc_q, exc_d;

  fp32_t                 fa, fb;
  fp_class_e             ca, cb;
  logic [SIG_W-1:0]      ma, mb;
  logic signed [E_W-1:0] exp_raw;
  logic [REM_W-1:0]      diff;
  logic                  qbit;
  logic [31:0]           rp_result;
  logic                  rp_exc;

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign_i   (sign_q),
    .exp_i    (exp_q),
    .quo_i    (quo_q),
    .sticky_i (rem_q != '0),
    .result_o (rp_result),
    .exc_o    (rp_exc)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign exception = exc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      mb_q     <= '0;
      quo_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      mb_q     <= mb_d;
      quo_q    <= quo_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    mb_d     = mb_q;
    quo_d    = quo_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    exc_d    = exc_q;

    fa      = fp_fields(a_q);
    fb      = fp_fields(b_q);
    ca      = fp_classify(fa);
    cb      = fp_classify(fb);
    ma      = {1'b1, fa.frac};
    mb      = {1'b1, fb.frac};
    exp_raw = E_W'({2'b00, fa.exp}) - E_W'({2'b00, fb.exp}) + E_W'(EXP_BIAS);

    // Restoring step: remainder always stays below 2*divisor.
    qbit = (rem_q >= {1'b0, mb_q});
    diff = qbit ? (rem_q - {1'b0, mb_q}) : rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        sign_d  = fa.sign ^ fb.sign;
        state_d = S_DONE;
        if (ca == FP_NAN || cb == FP_NAN ||
            (ca == FP_ZERO && cb == FP_ZERO) ||
            (ca == FP_INF  && cb == FP_INF)) begin
          result_d = QNAN;
          exc_d    = 1'b1;
        end else if (ca == FP_INF) begin
          result_d = sign_d ? NEG_INF : POS_INF;
          exc_d    = 1'b0;
        end else if (cb == FP_ZERO) begin
          result_d = sign_d ? NEG_INF : POS_INF;
          exc_d    = 1'b1;
        end else if (cb == FP_INF || ca == FP_ZERO) begin
          result_d = {sign_d, 31'd0};
          exc_d    = 1'b0;
        end else begin
          // Pre-scale so the quotient lands in [1,2) and its first bit is 1.
          if (ma < mb) begin
            rem_d = {ma, 1'b0};
            exp_d = exp_raw - E_W'(1);
          end else begin
            rem_d = {1'b0, ma};
            exp_d = exp_raw;
          end
          mb_d    = mb;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        quo_d = {quo_q[Q_W-2:0], qbit};
        rem_d = {diff[REM_W-2:0], 1'b0};
        if (cnt_q == CNT_W'(Q_W - 1)) begin
          cnt_d   = '0;
          state_d = S_ROUND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ROUND: begin
        result_d = rp_result;
        exc_d    = rp_exc;
        state_d  = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fp32_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_seq_divider
// Purpose  : Self-checking bench for fp32_seq_divider: directed cases, random
//            operands against an exact integer-division reference, handshake
//            backpressure and mid-division reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        exception;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fp32_seq_divider dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .exception (exception)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Exact reference: long division with many extra bits, then RNE on the
  // exact remainder; special cases taken straight from the operand classes.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic x, output int lat);
    logic s;
    int   ea, eb, e, sh;
    bit   za, zb, ia, ib, na, nb, up;
    longint unsigned ma, mb, n, q, rm, mant, low, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    lat = 2;
    x   = 1'b0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      r = 32'h7FC00000; x = 1'b1;
    end else if (ia) begin
      r = {s, 8'hFF, 23'd0};
    end else if (zb) begin
      r = {s, 8'hFF, 23'd0}; x = 1'b1;
    end else if (ib || za) begin
      r = {s, 31'd0};
    end else begin
      lat = 29;
      ma  = {40'd0, 1'b1, a[22:0]};
      mb  = {40'd0, 1'b1, b[22:0]};
      n   = ma << 38;
      q   = n / mb;
      rm  = n % mb;
      e   = ea - eb + 127;
      if ((q >> 38) != 0) sh = 15;
      else begin sh = 14; e = e - 1; end
      mant = q >> sh;
      low  = q & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      up   = (low > half) || ((low == half) && ((rm != 0) || mant[0]));
      if (up) mant = mant + 64'd1;
      if (mant == (64'd1 << 24)) begin mant = mant >> 1; e = e + 1; end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0}; x = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'd0}; x = 1'b1;
      end else begin
        r = {s, 8'(e), mant[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0:       v[30:23] = 8'h00;
      1:       v[30:0]  = {8'hFF, 23'd0};
      2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3, 4, 5, 6: v[30:23] = 8'($urandom_range(107, 147));
      default: v[30:23] = 8'($urandom_range(1, 254));
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want_r, input logic want_x,
                        input int want_lat, input int hold);
    int lat;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check_eq("idle_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(want_lat));
    check_eq("result", result, want_r);
    check_eq("exception", 32'(exception), 32'(want_x));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_result", result, want_r);
      check_eq("bp_exc", 32'(exception), 32'(want_x));
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("drain_valid", 32'(out_valid), 32'd0);
    check_eq("drain_ready", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        x;
    int          lat;
  } vec_t;

  vec_t dir[8];

  initial begin
    logic [31:0] rr;
    logic        rx;
    int          rl;
    logic [31:0] ra, rb;

    dir[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29};
    dir[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 29};
    dir[2] = '{32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 29};
    dir[3] = '{32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 2};
    dir[4] = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b1, 2};
    dir[5] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 2};
    dir[6] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 1'b1, 29};
    dir[7] = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b1, 29};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_exception", 32'(exception), 32'd0);
    reset = 1'b0;

    foreach (dir[i]) run_op(dir[i].a, dir[i].b, dir[i].r, dir[i].x, dir[i].lat, 0);

    // Backpressure: consumer stalls five cycles.
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, 5);

    // Reset in the middle of a division, then a clean operation.
    @(negedge clk);
    in_valid = 1'b1;
    A = 32'h40C00000;
    B = 32'h40000000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_exception", 32'(exception), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 29, 0);

    for (int i = 0; i < 60; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      ref_div(ra, rb, rr, rx, rl);
      run_op(ra, rb, rr, rx, rl, (i % 7 == 0) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
